// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU feeding the accumulator register.
//
// Runs one operation per accepted start request. ADD/SUB/AND/OR/XOR/PASS
// finish in a single cycle. MUL uses a shift-add multiplier and DIV a
// restoring divider, each taking WIDTH iteration cycles. The done pulse
// is the accumulator load strobe and result drives its data input.
//
// Build option:
//   ALU_DIV_EN  defined   -> restoring divider present, DIV returns a/b
//                            (b == 0 gives all ones with err set, no iterations)
//               undefined -> no divider logic; DIV completes in one cycle
//                            with result = 0 and err set
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   start   operation request, only looked at while idle
//   op      opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS, 6 MUL, 7 DIV)
//   a, b    operands (a is the current accumulator value)
//   busy    high whenever the unit is not idle
//   done    one-cycle completion pulse
//   result  registered result, held until the next completion
//   zero    result == 0
//   carry   carry out / borrow / nonzero product high half
//   ovf     signed overflow for ADD/SUB
//   err     divide by zero, or DIV requested without the divider
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_PASS = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_DIV  = 3'd7;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  // hi: partial product high half / remainder
  // lo: multiplier being shifted out / dividend shifted out, quotient shifted in
  // opd: multiplicand / divisor
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] opd_reg, opd_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg, zero_next;
  logic             carry_reg, carry_next;
  logic             ovf_reg, ovf_next;
  logic             err_reg, err_next;
`ifdef ALU_DIV_EN
  logic             is_div_reg, is_div_next;
`endif

  // Single-cycle datapath
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = a - b;

  // One shift-add step on the 2*WIDTH product {hi, lo}: add the
  // multiplicand into the high half when the multiplier LSB is set,
  // then shift the whole product right, carry bit included.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  assign mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opd_reg} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], lo_reg[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  // One restoring-divide step. The shifted remainder is WIDTH+1 bits; if
  // its top bit is set it certainly exceeds the divisor, so the low
  // WIDTH bits of the difference are already the correct new remainder.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_sub;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi, div_lo;
  assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
  assign div_sub   = {1'b0, div_shift[WIDTH-1:0]} - {1'b0, opd_reg};
  assign div_ok    = div_shift[WIDTH] | ~div_sub[WIDTH];
  assign div_hi    = div_ok ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo    = {lo_reg[WIDTH-2:0], div_ok};
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    opd_next    = opd_reg;
    result_next = result_reg;
    carry_next  = carry_reg;
    ovf_next    = ovf_reg;
    err_next    = err_reg;
`ifdef ALU_DIV_EN
    is_div_next = is_div_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = DONE;
          carry_next = 1'b0;
          ovf_next   = 1'b0;
          err_next   = 1'b0;
          case (op)
            OP_ADD: begin
              result_next = add_sum[WIDTH-1:0];
              carry_next  = add_sum[WIDTH];
              ovf_next    = (a[WIDTH-1] == b[WIDTH-1]) &&
                            (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              result_next = sub_diff;
              carry_next  = (a < b);
              ovf_next    = (a[WIDTH-1] != b[WIDTH-1]) &&
                            (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result_next = a & b;
            OP_OR:   result_next = a | b;
            OP_XOR:  result_next = a ^ b;
            OP_PASS: result_next = b;
            OP_MUL: begin
              // Flags stay as they were until the iteration completes.
              carry_next  = carry_reg;
              ovf_next    = ovf_reg;
              err_next    = err_reg;
              hi_next     = '0;
              lo_next     = a;
              opd_next    = b;
              cnt_next    = ITERS;
              state_next  = ITER;
`ifdef ALU_DIV_EN
              is_div_next = 1'b0;
`endif
            end
            OP_DIV: begin
`ifdef ALU_DIV_EN
              if (b == '0) begin
                result_next = '1;
                err_next    = 1'b1;
              end else begin
                carry_next  = carry_reg;
                ovf_next    = ovf_reg;
                err_next    = err_reg;
                hi_next     = '0;
                lo_next     = a;
                opd_next    = b;
                cnt_next    = ITERS;
                state_next  = ITER;
                is_div_next = 1'b1;
              end
`else
              result_next = '0;
              err_next    = 1'b1;
`endif
            end
            default: result_next = result_reg;
          endcase
        end
      end

      ITER: begin
        cnt_next = cnt_reg - 1'b1;
`ifdef ALU_DIV_EN
        if (is_div_reg) begin
          hi_next = div_hi;
          lo_next = div_lo;
        end else begin
          hi_next = mul_hi;
          lo_next = mul_lo;
        end
`else
        hi_next = mul_hi;
        lo_next = mul_lo;
`endif
        // Last step: publish the freshly computed value, never a partial one.
        if (cnt_reg == CW'(1)) begin
          state_next  = DONE;
          result_next = lo_next;
          carry_next  = |mul_hi;
          ovf_next    = 1'b0;
          err_next    = 1'b0;
`ifdef ALU_DIV_EN
          if (is_div_reg) carry_next = 1'b0;
`endif
        end
      end

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase

    zero_next = (result_next == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      opd_reg    <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b1;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
`ifdef ALU_DIV_EN
      is_div_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      opd_reg    <= opd_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      carry_reg  <= carry_next;
      ovf_reg    <= ovf_next;
      err_reg    <= err_next;
`ifdef ALU_DIV_EN
      is_div_reg <= is_div_next;
`endif
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign zero   = zero_reg;
  assign carry  = carry_reg;
  assign ovf    = ovf_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- scoreboard bench for alu_seq.
// The driver pushes the expected response of every accepted request into a
// queue; a monitor pops and compares on each done pulse, including latency.
module tb_alu_seq;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, zero, carry, ovf, err;
  logic [WIDTH-1:0] result;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .carry(carry), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b, res;
    logic        z, c, v, e;
    int          acc_cycle;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int sx, sy, ss;
    int unsigned ux, uy, uw;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    e.op = o; e.a = x; e.b = y; e.res = '0;
    e.c = 1'b0; e.v = 1'b0; e.e = 1'b0; e.lat = 1; e.acc_cycle = 0;
    case (o)
      3'd0: begin
        uw = ux + uy; e.res = uw[15:0]; e.c = (uw > 32'hFFFF);
        ss = sx + sy; e.v = (ss > 32767) || (ss < -32768);
      end
      3'd1: begin
        uw = ux - uy; e.res = uw[15:0]; e.c = (ux < uy);
        ss = sx - sy; e.v = (ss > 32767) || (ss < -32768);
      end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: e.res = x ^ y;
      3'd5: e.res = y;
      3'd6: begin
        uw = ux * uy; e.res = uw[15:0]; e.c = ((uw >> 16) != 0); e.lat = 17;
      end
      default: begin
`ifdef ALU_DIV_EN
        if (uy == 0) begin
          e.res = 16'hFFFF; e.e = 1'b1;
        end else begin
          uw = ux / uy; e.res = uw[15:0]; e.lat = 17;
        end
`else
        e.res = 16'h0000; e.e = 1'b1;
`endif
      end
    endcase
    e.z = (e.res == 16'h0000);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // Call at a negedge; waits (bounded) for IDLE, then pulses start for one edge.
  task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int guard;
    guard = 0;
    while (busy) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        checks++; failures++;
        $display("FAIL issue_wait_idle actual=busy required=idle");
        return;
      end
    end
    op = o; a = x; b = y; start = 1'b1;
    e = model(o, x, y);
    e.acc_cycle = cycle;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) chk("done_width", {31'd0, done}, 32'd0);
        if (done) begin
          if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done actual=done required=no_done result=%h", result);
          end else begin
            e = sbq.pop_front();
            $display("txn op=%0d a=%h b=%h result=%h z=%0b c=%0b v=%0b e=%0b lat=%0d",
                     e.op, e.a, e.b, result, zero, carry, ovf, err, cycle - e.acc_cycle);
            chk("result", {16'd0, result}, {16'd0, e.res});
            chk("flags_zcve", {28'd0, zero, carry, ovf, err}, {28'd0, e.z, e.c, e.v, e.e});
            chk("latency", cycle - e.acc_cycle, e.lat);
          end
        end
        prev_done = done;
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_result"}, {16'd0, result}, 32'd0);
    chk({tag, "_zcve"}, {28'd0, zero, carry, ovf, err}, 32'h8);
  endtask

  initial begin
    int guard;
    int prev_acc;
    exp_t e;
    logic [15:0] rb;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(3'd0, 16'h7FFF, 16'h0001);
    issue(3'd0, 16'hFFFF, 16'h0001);
    issue(3'd1, 16'h0003, 16'h0005);
    issue(3'd5, 16'hABCD, 16'h1234);
    issue(3'd6, 16'h0123, 16'h0010);
    issue(3'd6, 16'h8000, 16'h0002);
    issue(3'd7, 16'h0064, 16'h0007);
    issue(3'd7, 16'h0064, 16'h0000);

    // start pulsed during ITER must be ignored
    issue(3'd6, 16'h1111, 16'h0003);
    start = 1'b1; op = 3'd0; a = 16'h0001; b = 16'h0001;
    repeat (3) @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (busy && guard < 40) begin @(negedge clk); guard++; end
    chk("iter_drain", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("start_ignored_queue", sbq.size(), 0);

    // Reset in the middle of a MUL
    issue(3'd6, 16'hFFFF, 16'hFFFF);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sbq.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);  // monitor flags any stray done
    check_reset_outputs("post_reset");

    // Back-to-back with start held high, alternating AND/OR
    prev_acc = -1;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      guard = 0;
      while (busy && guard < 10) begin @(negedge clk); guard++; end
      op = (i % 2 == 0) ? 3'd2 : 3'd3;
      a = 16'($urandom);
      b = 16'($urandom);
      e = model(op, a, b);
      e.acc_cycle = cycle;
      sbq.push_back(e);
      if (prev_acc >= 0) chk("b2b_spacing", cycle - prev_acc, 2);
      prev_acc = cycle;
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);

    // Random stimulus
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: rb = 16'h0000;
        1: rb = 16'($urandom_range(1, 300));
        default: rb = 16'($urandom);
      endcase
      issue(3'($urandom_range(0, 7)), 16'($urandom), rb);
    end

    // Drain
    guard = 0;
    while ((busy || sbq.size() != 0) && guard < 60) begin @(negedge clk); guard++; end
    chk("drain_queue_empty", sbq.size(), 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential 16-bit ALU that sits directly upstream of the accumulator register and produces the value written into it. The block takes the current accumulator value and a second operand, and runs one operation per `start` request. Logic ops complete in one cycle; multiply and divide are iterative shift-add and restoring-divide units. A one-cycle `done` pulse serves as the accumulator's load strobe, and `result` drives the accumulator data input.

## Interface
- `WIDTH`, 16, operand/result width; the counter is sized for `WIDTH` iterations.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  input  1  operation request, sampled only in IDLE.
- `op`  input  3  opcode, latched with `start`.
- `a`  input  WIDTH  first operand (accumulator value), latched with `start`.
- `b`  input  WIDTH  second operand, latched with `start`.
- `busy`  output  1  high whenever state ≠ IDLE.
- `done`  output  1  one-cycle completion pulse (accumulator write enable).
- `result`  output  WIDTH  registered result, held until the next completion.
- `zero`  output  1  `result == 0`, updated with `result`.
- `carry`  output  1  carry/borrow/high-half flag, updated with `result`.
- `ovf`  output  1  signed overflow flag, updated with `result`.
- `err`  output  1  divide-by-zero or disabled op, updated with `result`.

## Operation
- Opcodes:
  - 000 ADD: `a+b`; `carry` = carry out; `ovf` = signed overflow.
  - 001 SUB: `a-b`; `carry` = borrow, i.e. `a<b` unsigned; `ovf` = signed overflow.
  - 010 AND, 011 OR, 100 XOR: bitwise.
  - 101 PASS: `result=b`.
  - 110 MUL: unsigned, low `WIDTH` bits of the product; `carry` = high half ≠ 0.
  - 111 DIV: unsigned quotient `a/b`; remainder discarded.
- `carry` and `ovf` are 0 for ops that do not define them. `err` is 0 except as stated for DIV.
- States: IDLE, ITER, DONE.
  - IDLE + `start` + single-cycle op (000–101): compute from `a`, `b`, register `result` and the flags, go to DONE.
  - IDLE + `start` + MUL/DIV: latch operands, clear the partial product or remainder, load the counter with `WIDTH`, go to ITER.
  - ITER: one shift-add (MUL) or one restoring subtract step (DIV) per cycle. The counter decrements each cycle; when it reaches 0, register `result` and the flags and go to DONE.
  - DONE: `done`=1 for exactly this cycle, then go to IDLE.
- `start` is ignored in ITER and DONE; it is neither queued nor allowed to abort. A new request is accepted on the first IDLE cycle.
- DIV with `b==0`: no iterations. Go IDLE→DONE with `result`=all ones and `err`=1.
- Reset asserted at any time, including mid-iteration: state goes to IDLE, `result`=0, `zero`=1, `carry`=`ovf`=`err`=`busy`=`done`=0. No partial result is ever presented.

## Timing
- `start` is sampled at rising edge k.
- Single-cycle ops: `done`, `result` and flags are valid during cycle k+1, giving latency 1. `busy` is high in cycle k+1 only.
- MUL/DIV: ITER spans cycles k+1..k+`WIDTH`. DONE and `done` fall in cycle k+`WIDTH`+1, giving latency 17 at `WIDTH`=16.
- Back-to-back throughput: one single-cycle op every 2 cycles; one MUL/DIV every 18 cycles.
- Outputs are registered only. `a`, `b` and `op` may change freely after the accepting edge.

## Configuration
- `ALU_DIV_EN` defined: the restoring divider is compiled in, and DIV behaves as specified above.
- `ALU_DIV_EN` undefined: the divider logic is absent. DIV completes in 1 cycle with `result`=0, `zero`=1 and `err`=1, regardless of `b`.

## Test plan
- Reset: hold `reset`=0, then release. All outputs read 0 except `zero`=1. Assert `reset` mid-ITER of a MUL: `busy` falls immediately and `done` never pulses.
- ADD 0x7FFF+0x0001: `done` at latency 1 with `result`=0x8000, `ovf`=1, `carry`=0. ADD 0xFFFF+0x0001: `result`=0x0000, `zero`=1, `carry`=1.
- SUB 0x0003−0x0005: `result`=0xFFFE, `carry`=1, `ovf`=0. PASS with `b`=0x1234: `result`=0x1234.
- MUL 0x0123×0x0010: `done` exactly 17 cycles after `start` with `result`=0x1230, `carry`=0. MUL 0x8000×0x0002: `result`=0x0000, `carry`=1, `zero`=1. A `start` pulsed during ITER is ignored.
- DIV 0x0064/0x0007 with `ALU_DIV_EN`: `result`=0x000E at latency 17. DIV 0x0064/0x0000: `result`=0xFFFF, `err`=1 at latency 1. Without the macro, any DIV gives `result`=0, `err`=1 at latency 1.
- Back-to-back: `start` held high continuously with alternating AND/OR ops. A new op is accepted every 2 cycles, and each `done` pulse is exactly 1 cycle wide.
